// File: rtl/pulse_arb_pkg.sv
// pulse_arb_pkg: shared FSM state encodings and default operand width for pulse_arbiter
package pulse_arb_pkg;
  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_ACK   = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam int PA_W = 8;
endpackage

// File: rtl/max_cmp.sv
// max_cmp: unsigned max of x and y from the carry-out of x + ~y + 1 (no carry means x < y)
module max_cmp
  import pulse_arb_pkg::*;
#(
  parameter int W = PA_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] max
);
  logic c_out;
  assign c_out = 1'(({1'b0, x} + {1'b0, ~y} + (W+1)'(1)) >> W);
  assign max = c_out ? x : y;
endmodule

// File: rtl/pulse_arbiter.sv
// pulse_arbiter: round-robin two-channel max(x,y)-cycle pulse generator; ZERO_SKIP_EN drops zero-length grants
module pulse_arbiter
  import pulse_arb_pkg::*;
#(
  parameter int W = PA_W
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         dav0_,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] y0,
  output logic         rfd0,
  input  logic         dav1_,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  output logic         rfd1,
  output logic         out,
  output logic         chan
);
  logic [1:0] star;
  logic [W-1:0] count;
  logic [W-1:0] m;
  logic ptr;
  logic req;
  logic g;
  logic dav_g;
  always_comb begin
    req   = !dav0_ || !dav1_;
    g     = (!dav0_ && !dav1_) ? ptr : !dav1_;
    dav_g = chan ? dav1_ : dav0_;
  end
  max_cmp #(.W(W)) u_max (
    .x   (g ? x1 : x0),
    .y   (g ? y1 : y0),
    .max (m)
  );
  always_ff @(posedge clock) begin
    if (!reset_) begin
      star <= S_WAIT;
      rfd0 <= 1'b1;
      rfd1 <= 1'b1;
      out  <= 1'b0;
      chan <= 1'b0;
      ptr  <= 1'b0;
    end else begin
      case (star)
        S_WAIT: if (req) begin
          chan  <= g;
          count <= m;
          rfd0  <= 1'b0;
          rfd1  <= 1'b0;
          ptr   <= ~g;
          star  <= S_ACK;
        end
        S_ACK: if (dav_g) begin
`ifdef ZERO_SKIP_EN
          if (count == '0) begin
            rfd0 <= 1'b1;
            rfd1 <= 1'b1;
            star <= S_WAIT;
          end else begin
            out  <= 1'b1;
            star <= S_PULSE;
          end
`else
          out  <= 1'b1;
          star <= S_PULSE;
`endif
        end
        S_PULSE: begin
          count <= count - W'(1);
          if (count == W'(1)) begin
            out  <= 1'b0;
            rfd0 <= 1'b1;
            rfd1 <= 1'b1;
            star <= S_WAIT;
          end
        end
        default: begin
          star <= S_WAIT;
          out  <= 1'b0;
          rfd0 <= 1'b1;
          rfd1 <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_arbiter.sv
// tb_pulse_arbiter: directed checks of grant order, pulse length, handshake and reset abort
module tb_pulse_arbiter;
  logic clock = 1'b0;
  logic reset_ = 1'b0;
  logic dav0_ = 1'b1;
  logic dav1_ = 1'b1;
  logic [7:0] x0 = '0;
  logic [7:0] y0 = '0;
  logic [7:0] x1 = '0;
  logic [7:0] y1 = '0;
  logic rfd0, rfd1, out, chan;
  int n_cmp = 0;
  int n_bad = 0;
  pulse_arbiter #(.W(8)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .dav0_  (dav0_),
    .x0     (x0),
    .y0     (y0),
    .rfd0   (rfd0),
    .dav1_  (dav1_),
    .x1     (x1),
    .y1     (y1),
    .rfd1   (rfd1),
    .out    (out),
    .chan   (chan)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    reset_ = 1'b0;
    dav0_ = 1'b1;
    dav1_ = 1'b1;
    tick();
    tick();
    reset_ = 1'b1;
  endtask
  // Counts high cycles starting from the current sample; stops after the falling sample.
  task automatic measure(input string tag, input int len, input logic ch);
    int n = 0;
    logic rfd_seen = 1'b0;
    logic ch_bad = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (out) begin
        n++;
        rfd_seen |= rfd0 | rfd1;
        ch_bad |= (chan !== ch);
      end else if (n > 0) break;
      tick();
    end
    check({tag, "_len"}, n, len);
    check({tag, "_chan"}, ch_bad, 0);
    check({tag, "_rfd_during"}, rfd_seen, 0);
    check({tag, "_rfd0_after"}, rfd0, 1);
    check({tag, "_rfd1_after"}, rfd1, 1);
  endtask
  initial begin
    int highs;
    int bad_star;
    logic [3:0] seq;
    do_reset();
    check("rst_out", out, 0);
    check("rst_rfd0", rfd0, 1);
    check("rst_rfd1", rfd1, 1);
    check("rst_chan", chan, 0);
    check("rst_star", dut.star, 0);
    // ch0 alone: max(5,9)=9
    x0 = 8'd5; y0 = 8'd9; dav0_ = 1'b0;
    tick();
    check("t1_rfd0_grant", rfd0, 0);
    check("t1_rfd1_grant", rfd1, 0);
    check("t1_out_grant", out, 0);
    dav0_ = 1'b1;
    tick();
    measure("t1", 9, 1'b0);
    // simultaneous requests: ch0 (7,3) first, ch1 (2,4) next
    do_reset();
    x0 = 8'd7; y0 = 8'd3; x1 = 8'd2; y1 = 8'd4;
    dav0_ = 1'b0; dav1_ = 1'b0;
    tick();
    check("t2_chan0", chan, 0);
    dav0_ = 1'b1;
    tick();
    measure("t2a", 7, 1'b0);
    tick();
    check("t2_chan1", chan, 1);
    dav1_ = 1'b1;
    tick();
    measure("t2b", 4, 1'b1);
    check("t2_ptr", dut.ptr, 0);
    // continuous requests alternate: ch0 max(3,1)=3, ch1 max(2,2)=2
    do_reset();
    x0 = 8'd3; y0 = 8'd1; x1 = 8'd2; y1 = 8'd2;
    dav0_ = 1'b0; dav1_ = 1'b0;
    seq = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seq[k] = chan;
      if (k % 2 == 0) dav0_ = 1'b1; else dav1_ = 1'b1;
      tick();
      dav0_ = 1'b0; dav1_ = 1'b0;
      measure($sformatf("t3_%0d", k), (k % 2 == 0) ? 3 : 2, 1'(k % 2));
    end
    check("t3_seq", seq, 4'b1010);
    dav0_ = 1'b1; dav1_ = 1'b1;
    // zero operands on ch1
    do_reset();
    x1 = 8'd0; y1 = 8'd0; dav1_ = 1'b0;
    tick();
    dav1_ = 1'b1;
    tick();
`ifdef ZERO_SKIP_EN
    check("t4_out", out, 0);
    check("t4_rfd1", rfd1, 1);
    check("t4_star", dut.star, 0);
`else
    measure("t4", 256, 1'b1);
`endif
    // reset during cycle 3 of a 10-cycle pulse
    do_reset();
    x0 = 8'd10; y0 = 8'd4; dav0_ = 1'b0;
    tick();
    dav0_ = 1'b1;
    tick();
    tick();
    tick();
    check("t5_out_pre", out, 1);
    reset_ = 1'b0;
    tick();
    check("t5_out", out, 0);
    check("t5_rfd0", rfd0, 1);
    check("t5_rfd1", rfd1, 1);
    check("t5_star", dut.star, 0);
    reset_ = 1'b1;
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      highs += int'(out);
    end
    check("t5_no_resume", highs, 0);
    // slow release holds S_ACK
    do_reset();
    x0 = 8'd6; y0 = 8'd2; dav0_ = 1'b0;
    tick();
    highs = 0;
    bad_star = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      highs += int'(out);
      bad_star += int'(dut.star !== 2'd1);
    end
    check("t6_out_held", highs, 0);
    check("t6_star_ack", bad_star, 0);
    dav0_ = 1'b1;
    check("t6_out_pre", out, 0);
    tick();
    check("t6_out_start", out, 1);
    measure("t6", 6, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
